// File: rtl/cache_line_fill.sv
// Miss-side line fill engine: one burst read per miss, early critical word.
// Define CACHE_FILL_CRIT_WORD_FIRST_EN for wrap-ordered critical-word-first bursts.
module cache_line_fill #(
    parameter int ADDR_WIDTH = 32,
    parameter int WORD_WIDTH = 32,
    parameter int LINE_WORDS = 8,
    localparam int OFFSET_BITS = $clog2(LINE_WORDS * 4),
    localparam int WIDX_BITS = OFFSET_BITS - 2
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             missValid,
    output logic                             missReady,
    input  logic [ADDR_WIDTH-1:0]            missAddr,
    output logic                             memReqValid,
    input  logic                             memReqReady,
    output logic [ADDR_WIDTH-1:0]            memReqAddr,
    input  logic                             memRdValid,
    input  logic [WORD_WIDTH-1:0]            memRdData,
    output logic                             critValid,
    output logic [WORD_WIDTH-1:0]            critData,
    output logic                             fillValid,
    input  logic                             fillReady,
    output logic [LINE_WORDS*WORD_WIDTH-1:0] fillLine,
    output logic [ADDR_WIDTH-1:0]            fillAddr,
    output logic [OFFSET_BITS-1:0]           fillOffset,
    output logic                             busy
);

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        FILL,
        DONE
    } state_t;

    state_t state;

    logic [WIDX_BITS-1:0]  beat;
    logic [WIDX_BITS-1:0]  crit_idx;
    logic [WIDX_BITS-1:0]  start_idx;
    logic [WIDX_BITS-1:0]  widx;
    logic [WIDX_BITS-1:0]  miss_idx;
    logic [WIDX_BITS-1:0]  start_idx_d;
    logic [ADDR_WIDTH-1:0] line_addr;
    logic [ADDR_WIDTH-1:0] req_addr;
    logic                  last_beat;
    logic [WORD_WIDTH-1:0] line_q [LINE_WORDS];

    always_comb begin
        miss_idx  = missAddr[OFFSET_BITS-1:2];
        line_addr = {missAddr[ADDR_WIDTH-1:OFFSET_BITS], {OFFSET_BITS{1'b0}}};
`ifdef CACHE_FILL_CRIT_WORD_FIRST_EN
        req_addr    = {missAddr[ADDR_WIDTH-1:2], 2'b00};
        start_idx_d = miss_idx;
`else
        req_addr    = line_addr;
        start_idx_d = '0;
`endif
    end

    // Word index wraps inside the line for wrap-ordered bursts.
    always_comb begin
        widx      = start_idx + beat;
        last_beat = (beat == WIDX_BITS'(LINE_WORDS - 1));
    end

    for (genvar gi = 0; gi < LINE_WORDS; gi++) begin : g_pack
        assign fillLine[gi*WORD_WIDTH +: WORD_WIDTH] = line_q[gi];
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= IDLE;
            missReady   <= 1'b0;
            memReqValid <= 1'b0;
            memReqAddr  <= '0;
            critValid   <= 1'b0;
            critData    <= '0;
            fillValid   <= 1'b0;
            fillAddr    <= '0;
            fillOffset  <= '0;
            busy        <= 1'b0;
            beat        <= '0;
            crit_idx    <= '0;
            start_idx   <= '0;
            for (int i = 0; i < LINE_WORDS; i++) begin
                line_q[i] <= '0;
            end
        end else begin
            critValid <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (missValid && missReady) begin
                        missReady   <= 1'b0;
                        memReqValid <= 1'b1;
                        memReqAddr  <= req_addr;
                        fillAddr    <= line_addr;
                        fillOffset  <= missAddr[OFFSET_BITS-1:0];
                        crit_idx    <= miss_idx;
                        start_idx   <= start_idx_d;
                        busy        <= 1'b1;
                        state       <= REQ;
                    end else begin
                        missReady <= 1'b1;
                    end
                end
                REQ: begin
                    if (memReqReady) begin
                        memReqValid <= 1'b0;
                        beat        <= '0;
                        state       <= FILL;
                    end
                end
                FILL: begin
                    if (memRdValid) begin
                        line_q[widx] <= memRdData;
                        beat         <= beat + 1'b1;
                        if (widx == crit_idx) begin
                            critValid <= 1'b1;
                            critData  <= memRdData;
                        end
                        if (last_beat) begin
                            fillValid <= 1'b1;
                            state     <= DONE;
                        end
                    end
                end
                DONE: begin
                    // missReady stays low here, giving one bubble cycle in IDLE.
                    if (fillReady) begin
                        fillValid <= 1'b0;
                        busy      <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_cache_line_fill.sv
// Directed table-driven bench for cache_line_fill.
// Expectations follow CACHE_FILL_CRIT_WORD_FIRST_EN when it is defined.
module tb_cache_line_fill;

    logic         clk;
    logic         rst_n;
    logic         missValid;
    logic         missReady;
    logic [31:0]  missAddr;
    logic         memReqValid;
    logic         memReqReady;
    logic [31:0]  memReqAddr;
    logic         memRdValid;
    logic [31:0]  memRdData;
    logic         critValid;
    logic [31:0]  critData;
    logic         fillValid;
    logic         fillReady;
    logic [255:0] fillLine;
    logic [31:0]  fillAddr;
    logic [4:0]   fillOffset;
    logic         busy;

    int total;
    int bad;

    cache_line_fill dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .missValid   (missValid),
        .missReady   (missReady),
        .missAddr    (missAddr),
        .memReqValid (memReqValid),
        .memReqReady (memReqReady),
        .memReqAddr  (memReqAddr),
        .memRdValid  (memRdValid),
        .memRdData   (memRdData),
        .critValid   (critValid),
        .critData    (critData),
        .fillValid   (fillValid),
        .fillReady   (fillReady),
        .fillLine    (fillLine),
        .fillAddr    (fillAddr),
        .fillOffset  (fillOffset),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0]  addr;
        logic [31:0]  req;
        logic [31:0]  faddr;
        logic [4:0]   foff;
        logic [31:0]  crit;
        int           cbeat;
        logic [255:0] line;
        logic [31:0]  base;
        int           rdelay;
        bit           gap;
        int           hold;
        bit           poke;
    } vec_t;

    vec_t vec [5];

    task automatic chk(input string nm, input logic [255:0] act,
                       input logic [255:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic run_fill(input int i);
        vec_t v;
        int n;
        int cbeat;
        int ccount;
        bit early;
        bit unstable;
        bit ready_bad;
        logic [255:0] snap;
        v = vec[i];
        n = 0;
        while (!missReady && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("miss_ready_idle", missReady, 1);
        missAddr  = v.addr;
        missValid = 1;
        @(negedge clk);
        if (!v.poke) missValid = 0;
        chk("req_valid", memReqValid, 1);
        chk("req_addr", memReqAddr, v.req);
        chk("busy_req", busy, 1);
        chk("miss_ready_req", missReady, 0);
        unstable = 0;
        repeat (v.rdelay) begin
            @(negedge clk);
            if (!memReqValid || memReqAddr !== v.req) unstable = 1;
        end
        chk("req_stable", unstable, 0);
        memReqReady = 1;
        @(negedge clk);
        memReqReady = 0;
        chk("req_drop", memReqValid, 0);
        cbeat = -1;
        ccount = 0;
        early = 0;
        ready_bad = 0;
        for (int k = 0; k < 8; k++) begin
            if (v.gap && (k % 2 == 1)) begin
                @(negedge clk);
                if (critValid) ccount++;
                if (fillValid) early = 1;
            end
            memRdValid = 1;
            memRdData  = v.base + 32'(k);
            @(negedge clk);
            memRdValid = 0;
            if (critValid) begin
                ccount++;
                cbeat = k;
            end
            if (fillValid && k != 7) early = 1;
            if (missReady) ready_bad = 1;
        end
        chk("fill_valid", fillValid, 1);
        chk("no_early_fill", early, 0);
        chk("fill_line", fillLine, v.line);
        chk("fill_addr", fillAddr, v.faddr);
        chk("fill_offset", fillOffset, v.foff);
        chk("crit_data", critData, v.crit);
        chk("crit_beat", cbeat, v.cbeat);
        snap = fillLine;
        unstable = 0;
        repeat (v.hold) begin
            @(negedge clk);
            if (critValid) ccount++;
            if (!fillValid || fillLine !== snap) unstable = 1;
            if (memReqValid || missReady) unstable = 1;
        end
        chk("crit_once", ccount, 1);
        chk("done_stable", unstable, 0);
        chk("miss_ready_busy", ready_bad, 0);
        missValid = 0;
        fillReady = 1;
        @(negedge clk);
        fillReady = 0;
        chk("fill_drop", fillValid, 0);
        chk("bubble", missReady, 0);
        chk("busy_idle", busy, 0);
        @(negedge clk);
        chk("miss_ready_back", missReady, 1);
        chk("no_second_req", memReqValid, 0);
    endtask

    initial begin
        bit stray;
        clk = 0;
        rst_n = 0;
        missValid = 0;
        missAddr = '0;
        memReqReady = 0;
        memRdValid = 0;
        memRdData = '0;
        fillReady = 0;
        total = 0;
        bad = 0;

`ifdef CACHE_FILL_CRIT_WORD_FIRST_EN
        vec[0] = '{32'h1234, 32'h1234, 32'h1220, 5'd20, 32'hA0, 0,
                   {32'hA2, 32'hA1, 32'hA0, 32'hA7, 32'hA6, 32'hA5, 32'hA4, 32'hA3},
                   32'hA0, 2, 1'b0, 0, 1'b0};
        vec[1] = '{32'h101F, 32'h101C, 32'h1000, 5'd31, 32'hA0, 0,
                   {32'hA0, 32'hA7, 32'hA6, 32'hA5, 32'hA4, 32'hA3, 32'hA2, 32'hA1},
                   32'hA0, 2, 1'b1, 4, 1'b0};
        vec[3] = '{32'hFFFFFFE8, 32'hFFFFFFE8, 32'hFFFFFFE0, 5'd8, 32'hA0, 0,
                   {32'hA5, 32'hA4, 32'hA3, 32'hA2, 32'hA1, 32'hA0, 32'hA7, 32'hA6},
                   32'hA0, 1, 1'b0, 1, 1'b0};
        vec[4] = '{32'h1234, 32'h1234, 32'h1220, 5'd20, 32'hB0, 0,
                   {32'hB2, 32'hB1, 32'hB0, 32'hB7, 32'hB6, 32'hB5, 32'hB4, 32'hB3},
                   32'hB0, 1, 1'b1, 4, 1'b0};
`else
        vec[0] = '{32'h1234, 32'h1220, 32'h1220, 5'd20, 32'hA5, 5,
                   {32'hA7, 32'hA6, 32'hA5, 32'hA4, 32'hA3, 32'hA2, 32'hA1, 32'hA0},
                   32'hA0, 2, 1'b0, 0, 1'b0};
        vec[1] = '{32'h101F, 32'h1000, 32'h1000, 5'd31, 32'hA7, 7,
                   {32'hA7, 32'hA6, 32'hA5, 32'hA4, 32'hA3, 32'hA2, 32'hA1, 32'hA0},
                   32'hA0, 2, 1'b1, 4, 1'b0};
        vec[3] = '{32'hFFFFFFE8, 32'hFFFFFFE0, 32'hFFFFFFE0, 5'd8, 32'hA2, 2,
                   {32'hA7, 32'hA6, 32'hA5, 32'hA4, 32'hA3, 32'hA2, 32'hA1, 32'hA0},
                   32'hA0, 1, 1'b0, 1, 1'b0};
        vec[4] = '{32'h1234, 32'h1220, 32'h1220, 5'd20, 32'hB5, 5,
                   {32'hB7, 32'hB6, 32'hB5, 32'hB4, 32'hB3, 32'hB2, 32'hB1, 32'hB0},
                   32'hB0, 1, 1'b1, 4, 1'b0};
`endif
        vec[2] = '{32'h2000, 32'h2000, 32'h2000, 5'd0, 32'hA0, 0,
                   {32'hA7, 32'hA6, 32'hA5, 32'hA4, 32'hA3, 32'hA2, 32'hA1, 32'hA0},
                   32'hA0, 0, 1'b0, 2, 1'b1};

        // Reset with stray beats on the read port.
        memRdValid = 1;
        memRdData = 32'hDEAD;
        repeat (3) @(negedge clk);
        memRdValid = 0;
        chk("rst_fill_valid", fillValid, 0);
        chk("rst_crit_valid", critValid, 0);
        chk("rst_req_valid", memReqValid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_line", fillLine, 0);
        rst_n = 1;
        @(negedge clk);
        chk("rst_miss_ready", missReady, 1);

        for (int i = 0; i < 4; i++) run_fill(i);

        // Abort a fill after beat 3, then feed stray beats.
        missAddr = 32'h1234;
        missValid = 1;
        @(negedge clk);
        missValid = 0;
        memReqReady = 1;
        @(negedge clk);
        memReqReady = 0;
        for (int k = 0; k < 4; k++) begin
            memRdValid = 1;
            memRdData = 32'hC0 + 32'(k);
            @(negedge clk);
        end
        memRdValid = 0;
        rst_n = 0;
        @(negedge clk);
        chk("abort_fill_valid", fillValid, 0);
        chk("abort_crit_valid", critValid, 0);
        chk("abort_busy", busy, 0);
        chk("abort_line", fillLine, 0);
        chk("abort_crit_data", critData, 0);
        chk("abort_fill_addr", fillAddr, 0);
        rst_n = 1;
        stray = 0;
        for (int k = 0; k < 3; k++) begin
            memRdValid = 1;
            memRdData = 32'hE0 + 32'(k);
            @(negedge clk);
            if (critValid || fillValid || busy) stray = 1;
        end
        memRdValid = 0;
        chk("stray_ignored", stray, 0);
        chk("stray_line", fillLine, 0);
        chk("abort_miss_ready", missReady, 1);

        run_fill(4);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
